// File: rtl/flag_bank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// flag_arb_pkg
//   Shared definitions for the flag bank arbiter and its priority picker.
//   - arb_state_e : handshake state encoding (IDLE / PRESENT / RECOVER)
//   - FLAG_N_DEFAULT / FLAG_IDX_W_DEFAULT : default bank geometry
//   - clog2()     : elaboration-time ceil(log2(value)) helper
// ---------------------------------------------------------------------------
package flag_arb_pkg;

    localparam int unsigned FLAG_N_DEFAULT     = 8;
    localparam int unsigned FLAG_IDX_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/flag_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// flag_bank_arbiter_if
//   Event/vector bus between peripheral strobes, the arbiter and the consumer.
//   SET   : per-flag one-cycle set strobes (sources -> arbiter)
//   MASK  : per-flag presentation enables (consumer -> arbiter)
//   ACK   : consumer accepts VEC, honoured only while REQ=1
//   REQ   : a vector is being presented
//   VEC   : index of the presented flag
//   PEND  : raw latched flag state
//   ANY   : registered OR of PEND & MASK
//   modport slave  : the arbiter side
//   modport master : the source/consumer side
// ---------------------------------------------------------------------------
interface flag_bank_arbiter_if #(
    parameter int unsigned N     = flag_arb_pkg::FLAG_N_DEFAULT,
    parameter int unsigned IDX_W = flag_arb_pkg::FLAG_IDX_W_DEFAULT
);
    logic [N-1:0]     SET;
    logic [N-1:0]     MASK;
    logic             ACK;
    logic             REQ;
    logic [IDX_W-1:0] VEC;
    logic [N-1:0]     PEND;
    logic             ANY;

    modport slave (
        input  SET,
        input  MASK,
        input  ACK,
        output REQ,
        output VEC,
        output PEND,
        output ANY
    );

    modport master (
        output SET,
        output MASK,
        output ACK,
        input  REQ,
        input  VEC,
        input  PEND,
        input  ANY
    );
endinterface

// File: rtl/flag_prio_sel.sv
// ---------------------------------------------------------------------------
// flag_prio_sel
//   Combinational picker over a request vector (already masked by caller).
//   ROUND_ROBIN=0 : lowest set index wins; i_ptr is ignored.
//   ROUND_ROBIN=1 : first set index at or above i_ptr+1 (mod N), wrapping.
//   Ports:
//     i_req   : request vector
//     i_ptr   : last-serviced index (round-robin base)
//     o_idx   : winning index (0 when none)
//     o_valid : at least one request present
// ---------------------------------------------------------------------------
module flag_prio_sel #(
    parameter int unsigned N           = 8,
    parameter int unsigned IDX_W       = 3,
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_pos;

    // Scan N candidate positions in priority order; the first hit wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (ROUND_ROBIN) begin
                w_pos = IDX_W'((32'(i_ptr) + 32'd1 + k) % N);
            end else begin
                w_pos = IDX_W'(k);
            end
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/flag_bank_arbiter.sv
// ---------------------------------------------------------------------------
// flag_bank_arbiter
//   Bank of N event flags with synchronous set/clear and a single-consumer
//   REQ/VEC/ACK handshake. Flags latch on SET, one qualifying (PEND & MASK)
//   flag is presented at a time and is cleared when the consumer ACKs.
//   Service cadence: IDLE (select) -> PRESENT (REQ=1) -> RECOVER (dead cycle).
//
//   Ports:
//     CLK     : system clock, rising edge
//     RESET_n : asynchronous active-low reset
//     bus     : flag_bank_arbiter_if.slave (SET, MASK, ACK in; REQ, VEC,
//               PEND, ANY out)
//
//   Build option:
//     FLAG_ARB_ROUND_ROBIN_EN : when defined, selection is round-robin from
//     the last ACKed index; otherwise fixed lowest-index priority.
// ---------------------------------------------------------------------------
module flag_bank_arbiter
    import flag_arb_pkg::*;
#(
    parameter int unsigned N     = FLAG_N_DEFAULT,
    parameter int unsigned IDX_W = FLAG_IDX_W_DEFAULT
) (
    input logic              CLK,
    input logic              RESET_n,
    flag_bank_arbiter_if.slave bus
);

    localparam int unsigned IdxWReq = clog2(N);

    if (IDX_W != IdxWReq) begin : g_bad_idx_w
        $error("flag_bank_arbiter: IDX_W must equal ceil(log2(N))");
    end

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     w_pend_next;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_qual;
    logic [IDX_W-1:0] r_vec;
    logic [IDX_W-1:0] w_vec_next;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_ptr;
    logic             w_sel_valid;
    logic             w_ack_acc;
    logic             r_any;
    logic             w_any_next;

`ifdef FLAG_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;

    logic [IDX_W-1:0] r_ptr;

    // Pointer tracks the last ACKed vector; a mask-abort leaves it alone.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_ptr <= '0;
        end else if (w_ack_acc) begin
            r_ptr <= r_vec;
        end
    end

    assign w_ptr = r_ptr;
`else
    localparam bit RrEn = 1'b0;

    assign w_ptr = '0;
`endif

    // Selection looks at the registered flags, so REQ rises the cycle after
    // a flag first shows in PEND (SET -> REQ = 2 cycles).
    assign w_qual = r_pend & bus.MASK;

    flag_prio_sel #(
        .N           (N),
        .IDX_W       (IDX_W),
        .ROUND_ROBIN (RrEn)
    ) u_sel (
        .i_req   (w_qual),
        .i_ptr   (w_ptr),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        w_ack_acc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_vec_next   = w_sel_idx;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                // ACK takes precedence over a same-cycle mask drop.
                if (bus.ACK) begin
                    w_ack_acc    = 1'b1;
                    w_state_next = RECOVER;
                end else if (!bus.MASK[r_vec]) begin
                    w_state_next = IDLE;
                end
            end
            RECOVER: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // SET is OR-ed in after the clear, so a same-cycle set wins.
    assign w_clr       = w_ack_acc ? ({{(N-1){1'b0}}, 1'b1} << r_vec) : '0;
    assign w_pend_next = (r_pend & ~w_clr) | bus.SET;
    assign w_any_next  = |(w_pend_next & bus.MASK);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_vec   <= '0;
            r_any   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_vec   <= w_vec_next;
            r_any   <= w_any_next;
        end
    end

    assign bus.REQ  = (r_state == PRESENT);
    assign bus.VEC  = r_vec;
    assign bus.PEND = r_pend;
    assign bus.ANY  = r_any;

endmodule
